// File: rtl/ps2_kbd_pkg.sv
// Shared constants, types and the PET key layout for the PS/2 keyboard bridge.
package ps2_kbd_pkg;

  localparam logic [7:0] E0 = 8'hE0;
  localparam logic [7:0] E1 = 8'hE1;
  localparam logic [7:0] F0 = 8'hF0;

  localparam int ROW_W = 4;
  localparam int COL_W = 3;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} dec_state_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } key_map_t;

  typedef struct packed {
    logic             valid;
    logic             ext;
    logic [7:0]       code;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } hold_entry_t;

  function automatic key_map_t km(input int r, input int c);
    km = '{valid: 1'b1, row: ROW_W'(r), col: COL_W'(c)};
  endfunction

  // Shifted digits land on the PET top-row symbol keys; letters ignore shift.
  function automatic key_map_t ps2_map(input logic ext, input logic shift,
                                       input logic [7:0] code);
    ps2_map = '0;
    if (ext) begin
      case (code)
        8'h75, 8'h72: ps2_map = km(1, 6);
        8'h74, 8'h6B: ps2_map = km(0, 7);
        8'h6C:        ps2_map = km(0, 6);
        8'h71:        ps2_map = km(1, 7);
        default:      ;
      endcase
    end else begin
      case (code)
        8'h16: ps2_map = km(6, 6);
        8'h1E: ps2_map = km(7, 6);
        8'h26: ps2_map = km(6, 7);
        8'h25: ps2_map = km(7, 7);
        8'h2E: ps2_map = km(7, 4);
        8'h5A: ps2_map = km(6, 5);
        8'h29: ps2_map = km(9, 2);
        8'h66: ps2_map = km(1, 7);
        8'h15: ps2_map = km(2, 0);
        8'h1D: ps2_map = km(3, 0);
        8'h24: ps2_map = km(2, 1);
        8'h2D: ps2_map = km(3, 1);
        8'h2C: ps2_map = km(2, 2);
        8'h35: ps2_map = km(3, 2);
        8'h1C: ps2_map = km(4, 0);
        8'h1B: ps2_map = km(5, 0);
        8'h23: ps2_map = km(4, 1);
        8'h2B: ps2_map = km(5, 1);
        8'h1A: ps2_map = km(8, 1);
        8'h22: ps2_map = km(9, 1);
        default: ;
      endcase
      if (shift) begin
        case (code)
          8'h16: ps2_map = km(0, 0);
          8'h1E: ps2_map = km(1, 0);
          8'h26: ps2_map = km(0, 1);
          8'h25: ps2_map = km(1, 1);
          8'h2E: ps2_map = km(0, 2);
          default: ;
        endcase
      end
    end
  endfunction

  // Returns the zero-based function key number, or 4'hF for non-function codes.
  function automatic logic [3:0] fn_index(input logic [7:0] code);
    case (code)
      8'h05:   fn_index = 4'd0;
      8'h06:   fn_index = 4'd1;
      8'h04:   fn_index = 4'd2;
      8'h0C:   fn_index = 4'd3;
      8'h03:   fn_index = 4'd4;
      8'h0B:   fn_index = 4'd5;
      8'h83:   fn_index = 4'd6;
      8'h0A:   fn_index = 4'd7;
      8'h01:   fn_index = 4'd8;
      8'h09:   fn_index = 4'd9;
      8'h78:   fn_index = 4'd10;
      8'h07:   fn_index = 4'd11;
      default: fn_index = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchroniser, clock level filter, 11-bit frame check.
// Optional idle abort of partial frames when PS2_KBD_TIMEOUT_EN is defined.
module ps2_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       strobe,
  output logic       perr
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              filt_clk;
  logic [FCNT_W-1:0] filt_cnt;
  logic [9:0]        shreg;
  logic [3:0]        bit_cnt;
  logic              flip;
  logic              fall;
  logic              timeout;
  logic              frame_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  assign flip = (clk_sync[1] != filt_clk) && (filt_cnt == FCNT_W'(FILTER_LEN - 1));
  assign fall = flip && filt_clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (flip) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      to_cnt <= '0;
    else if (flip)
      to_cnt <= '0;
    else if (to_cnt != TO_W'(TIMEOUT_CYC))
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC)) && (bit_cnt != 4'd0);
`else
  assign timeout = 1'b0;
`endif

  // shreg holds {parity, data[7:0], start} once ten bits have been shifted in.
  assign frame_ok = !shreg[0] && (^shreg[9:1]) && data_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      rx_byte <= '0;
      strobe  <= 1'b0;
      perr    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      perr   <= 1'b0;
      if (fall) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            rx_byte <= shreg[8:1];
            strobe  <= 1'b1;
          end else begin
            perr <= 1'b1;
          end
        end else begin
          shreg   <= {data_sync[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (timeout) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_matrix_kbd.sv
// PS/2 set-2 to PET key matrix bridge with held-key table, Fn and modifier flags.
// Define PS2_KBD_TIMEOUT_EN to abort stalled partial frames in the receiver.
module ps2_matrix_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int ROWS        = 10,
  parameter int COLS        = 8,
  parameter int FN_COUNT    = 11,
  parameter int HOLD_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ps2_kbd_clk,
  input  logic                    ps2_kbd_data,
  input  logic [$clog2(ROWS)-1:0] keyrow,
  output logic [COLS-1:0]         keyin,
  output logic [FN_COUNT-1:0]     Fn,
  output logic [2:0]              mod,
  output logic                    perr,
  output logic                    ovf
);

  localparam int RSEL_W = $clog2(ROWS);
  localparam int HIDX_W = $clog2(HOLD_DEPTH);

  logic [7:0]        rx_byte;
  logic              rx_strobe;
  dec_state_t        state, state_nxt;
  logic [2:0]        skip_cnt, skip_nxt;
  logic              ev_valid, ev_ext, ev_brk;
  logic [7:0]        ev_code;
  logic [COLS-1:0]   matrix [ROWS];
  hold_entry_t       tbl [HOLD_DEPTH];
  logic [1:0]        shift_held, ctrl_held, alt_held;
  logic              hit, free_found, shared;
  logic [HIDX_W-1:0] hit_idx, free_idx;
  logic              is_shift, is_fn, key_ev, do_alloc, do_drop, do_free;
  logic [3:0]        fn_idx;
  key_map_t          key;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk(clk), .reset(reset), .ps2_clk(ps2_kbd_clk), .ps2_data(ps2_kbd_data),
    .rx_byte(rx_byte), .strobe(rx_strobe), .perr(perr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // Pause bytes are only counted in SKIP, so the second E1 inside it does not restart the skip.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    ev_valid  = 1'b0;
    ev_ext    = (state == EXT) || (state == EXTBRK);
    ev_brk    = (state == BRK) || (state == EXTBRK);
    ev_code   = rx_byte;
    if (rx_strobe) begin
      if (state == SKIP) begin
        skip_nxt = skip_cnt - 3'd1;
        if (skip_cnt == 3'd1) state_nxt = IDLE;
      end else if (rx_byte == E1) begin
        state_nxt = SKIP;
        skip_nxt  = 3'd7;
      end else if (rx_byte == E0 && state == IDLE) begin
        state_nxt = EXT;
      end else if (rx_byte == F0 && state == IDLE) begin
        state_nxt = BRK;
      end else if (rx_byte == F0 && state == EXT) begin
        state_nxt = EXTBRK;
      end else begin
        ev_valid  = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  assign mod      = {|ctrl_held, |alt_held, |shift_held};
  assign is_shift = !ev_ext && (ev_code == 8'h12 || ev_code == 8'h59);
  assign fn_idx   = fn_index(ev_code);
  assign is_fn    = !ev_ext && (fn_idx != 4'hF);
  assign key      = ps2_map(ev_ext, mod[0], ev_code);
  assign key_ev   = ev_valid && !(ev_ext && ev_code == 8'h12) && !is_shift && !is_fn
                    && (ev_code != 8'h14) && (ev_code != 8'h11);

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    shared     = 1'b0;
    for (int i = HOLD_DEPTH - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].ext == ev_ext && tbl[i].code == ev_code) begin
        hit     = 1'b1;
        hit_idx = HIDX_W'(i);
      end
      if (!tbl[i].valid) begin
        free_found = 1'b1;
        free_idx   = HIDX_W'(i);
      end
    end
    for (int i = 0; i < HOLD_DEPTH; i++)
      if (tbl[i].valid && HIDX_W'(i) != hit_idx && tbl[i].row == tbl[hit_idx].row
          && tbl[i].col == tbl[hit_idx].col)
        shared = 1'b1;
  end

  assign do_alloc = key_ev && !ev_brk && key.valid && !hit && free_found;
  assign do_drop  = key_ev && !ev_brk && key.valid && !hit && !free_found;
  assign do_free  = key_ev && ev_brk && hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) matrix[r] <= '1;
      for (int i = 0; i < HOLD_DEPTH; i++) tbl[i] <= '0;
      Fn         <= '0;
      shift_held <= '0;
      ctrl_held  <= '0;
      alt_held   <= '0;
      ovf        <= 1'b0;
    end else if (ev_valid) begin
      if (is_shift) shift_held[ev_code == 8'h59] <= !ev_brk;
      if (ev_code == 8'h14) ctrl_held[ev_ext] <= !ev_brk;
      if (ev_code == 8'h11) alt_held[ev_ext] <= !ev_brk;
      for (int i = 0; i < FN_COUNT; i++)
        if (is_fn && fn_idx == 4'(i)) Fn[i] <= !ev_brk;
      if (do_alloc)
        tbl[free_idx] <= '{valid: 1'b1, ext: ev_ext, code: ev_code, row: key.row, col: key.col};
      if (do_drop) ovf <= 1'b1;
      if (do_free) tbl[hit_idx].valid <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (do_alloc && key.row == ROW_W'(r) && key.col == COL_W'(c))
            matrix[r][c] <= 1'b0;
          else if (do_free && !shared && tbl[hit_idx].row == ROW_W'(r)
                   && tbl[hit_idx].col == COL_W'(c))
            matrix[r][c] <= 1'b1;
    end
  end

  always_comb begin
    keyin = '1;
    for (int r = 0; r < ROWS; r++)
      if (keyrow == RSEL_W'(r)) keyin = matrix[r];
  end

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Directed bench for ps2_matrix_kbd: PS/2 frames in, matrix/Fn/mod/flags checked.
module tb_ps2_matrix_kbd;

  localparam int ROWS        = 10;
  localparam int COLS        = 8;
  localparam int FN_COUNT    = 11;
  localparam int HOLD_DEPTH  = 8;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 16384;
  localparam int HALF        = 200;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                ps2_kbd_clk = 1'b1;
  logic                ps2_kbd_data = 1'b1;
  logic [3:0]          keyrow = '0;
  logic [COLS-1:0]     keyin;
  logic [FN_COUNT-1:0] Fn;
  logic [2:0]          mod;
  logic                perr;
  logic                ovf;

  int checks = 0;
  int errors = 0;
  int perr_pulses = 0;
  int perr_base;

  ps2_matrix_kbd #(
    .ROWS(ROWS), .COLS(COLS), .FN_COUNT(FN_COUNT), .HOLD_DEPTH(HOLD_DEPTH),
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .ps2_kbd_clk(ps2_kbd_clk), .ps2_kbd_data(ps2_kbd_data),
    .keyrow(keyrow), .keyin(keyin), .Fn(Fn), .mod(mod), .perr(perr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (perr === 1'b1) perr_pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives the first nbits of an 11-bit frame, optionally with inverted parity.
  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_kbd_data = frame[i];
      #(HALF);
      ps2_kbd_clk = 1'b0;
      #(HALF);
      ps2_kbd_clk = 1'b1;
    end
    ps2_kbd_data = 1'b1;
    #(HALF);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b0, 11);
  endtask

  task automatic checkRow(input string tag, input logic [3:0] row, input logic [7:0] exp);
    @(negedge clk);
    keyrow = row;
    #1;
    checkOutput(tag, 32'(keyin), 32'(exp));
  endtask

  task automatic checkFlags(input string tag, input logic [2:0] exp_mod,
                            input logic [FN_COUNT-1:0] exp_fn);
    @(negedge clk);
    checkOutput({tag, "_mod"}, 32'(mod), 32'(exp_mod));
    checkOutput({tag, "_fn"}, 32'(Fn), 32'(exp_fn));
  endtask

  initial begin
    logic [7:0] fill [9];
    fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h1C, 8'h1B, 8'h23};

    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    checkRow("reset_row6", 4'd6, 8'hFF);
    checkFlags("reset", 3'b000, '0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_perr", 32'(perr), 32'd0);

    sendByte(8'h16);
    checkRow("make1_row6", 4'd6, 8'hBF);
    checkRow("make1_row0", 4'd0, 8'hFF);
    sendByte(8'hF0); sendByte(8'h16);
    checkRow("brk1_row6", 4'd6, 8'hFF);

    sendByte(8'h12);
    checkFlags("lshift", 3'b001, '0);
    sendByte(8'h16);
    checkRow("shmake_row0", 4'd0, 8'hFE);
    checkRow("shmake_row6", 4'd6, 8'hFF);
    sendByte(8'hF0); sendByte(8'h12);
    checkFlags("shrel", 3'b000, '0);
    checkRow("shrel_row0", 4'd0, 8'hFE);
    sendByte(8'hF0); sendByte(8'h16);
    checkRow("shbrk_row0", 4'd0, 8'hFF);
    checkRow("shbrk_row6", 4'd6, 8'hFF);

    sendByte(8'h16); sendByte(8'h16); sendByte(8'h16);
    checkRow("rep_row6", 4'd6, 8'hBF);
    sendByte(8'hF0); sendByte(8'h16);
    checkRow("repbrk_row6", 4'd6, 8'hFF);

    for (int i = 0; i < HOLD_DEPTH; i++) sendByte(fill[i]);
    checkOutput("fill8_ovf", 32'(ovf), 32'd0);
    checkRow("fill8_row2", 4'd2, 8'hF8);
    checkRow("fill8_row3", 4'd3, 8'hF8);
    checkRow("fill8_row4", 4'd4, 8'hFE);
    checkRow("fill8_row5", 4'd5, 8'hFE);
    sendByte(fill[HOLD_DEPTH]);
    checkRow("full_row4", 4'd4, 8'hFE);
    checkOutput("full_ovf", 32'(ovf), 32'd1);
    checkRow("row10_oob", 4'd10, 8'hFF);
    checkRow("row15_oob", 4'd15, 8'hFF);
    sendByte(8'hF0); sendByte(8'h15);
    checkRow("free_row2", 4'd2, 8'hF9);
    sendByte(8'h23);
    checkRow("realloc_row4", 4'd4, 8'hFC);
    for (int i = 1; i <= HOLD_DEPTH; i++) begin
      sendByte(8'hF0);
      sendByte(fill[i]);
    end
    checkRow("clr_row2", 4'd2, 8'hFF);
    checkRow("clr_row3", 4'd3, 8'hFF);
    checkRow("clr_row4", 4'd4, 8'hFF);
    checkRow("clr_row5", 4'd5, 8'hFF);

    sendByte(8'h05);
    checkFlags("f1", 3'b000, 11'h001);
    sendByte(8'h78);
    checkFlags("f11", 3'b000, 11'h401);
    sendByte(8'hF0); sendByte(8'h05);
    checkFlags("f1rel", 3'b000, 11'h400);
    sendByte(8'hF0); sendByte(8'h78);
    sendByte(8'h07);
    checkFlags("f12", 3'b000, 11'h000);

    sendByte(8'h14);
    checkFlags("ctrl", 3'b100, '0);
    sendByte(8'hE0); sendByte(8'h11);
    checkFlags("ralt", 3'b110, '0);
    sendByte(8'hE0); sendByte(8'h12);
    checkFlags("fakeshift", 3'b110, '0);
    sendByte(8'hF0); sendByte(8'h14);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h11);
    checkFlags("ctrlalt_rel", 3'b000, '0);

    sendByte(8'h12); sendByte(8'h59);
    sendByte(8'hF0); sendByte(8'h12);
    checkFlags("rshift_held", 3'b001, '0);
    sendByte(8'hF0); sendByte(8'h59);
    checkFlags("shifts_rel", 3'b000, '0);

    sendByte(8'hE0); sendByte(8'h75);
    sendByte(8'hE0); sendByte(8'h72);
    checkRow("ext_row1", 4'd1, 8'hBF);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    checkRow("shared_row1", 4'd1, 8'hBF);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h72);
    checkRow("ext_brk_row1", 4'd1, 8'hFF);

    sendByte(8'hE1); sendByte(8'h14); sendByte(8'h77); sendByte(8'hE1);
    sendByte(8'hF0); sendByte(8'h14); sendByte(8'hF0); sendByte(8'h77);
    checkFlags("pause", 3'b000, '0);
    sendByte(8'h16);
    checkRow("after_pause_row6", 4'd6, 8'hBF);
    sendByte(8'hF0); sendByte(8'h16);

    perr_base = perr_pulses;
    applyStimulus(8'h16, 1'b1, 11);
    checkOutput("perr_pulse", 32'(perr_pulses - perr_base), 32'd1);
    checkRow("perr_row6", 4'd6, 8'hFF);
    sendByte(8'h16);
    checkRow("perr_recover_row6", 4'd6, 8'hBF);
    sendByte(8'hF0); sendByte(8'h16);
    checkRow("perr_final_row6", 4'd6, 8'hFF);

`ifdef PS2_KBD_TIMEOUT_EN
    perr_base = perr_pulses;
    applyStimulus(8'h16, 1'b0, 5);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    sendByte(8'h16);
    checkRow("timeout_row6", 4'd6, 8'hBF);
    checkOutput("timeout_no_perr", 32'(perr_pulses - perr_base), 32'd0);
`endif

    checkOutput("ovf_sticky", 32'(ovf), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_matrix_kbd.md
# ps2_matrix_kbd

Parametrised PS/2-to-key-matrix bridge, the next generation of the PET keyboard front end. It receives PS/2 set-2 scan codes and tracks E0-extended and E1 (Pause) sequences. It keeps a held-key table, so a release always clears the exact matrix position its make set, even when shift changed in between. It drives an active-low ROWS×COLS matrix read by the machine's keyboard scanner (PIA row select in, column byte out), plus function-key and modifier flags for the OSD/core control logic.

## Interface
- ROWS, 10, matrix rows.
- COLS, 8, matrix columns (bits per row).
- FN_COUNT, 11, function keys reported (F1..F<FN_COUNT>, max 12).
- HOLD_DEPTH, 8, held-key table entries.
- FILTER_LEN, 4, consecutive equal samples required to accept a PS/2 clock level.
- TIMEOUT_CYC, 16384, idle clk cycles that abort a partial frame (see Configuration).
---
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; one clock domain only.
- ps2_kbd_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_kbd_data  in  1  raw PS/2 data, asynchronous.
- keyrow  in  $clog2(ROWS)  row select.
- keyin  out  COLS  active-low columns of selected row; all ones if keyrow ≥ ROWS.
- Fn  out  FN_COUNT  level per function key, 1 = held.
- mod  out  3  {ctrl, alt, shift}, 1 = held; left/right shift merged.
- perr  out  1  one-cycle pulse on a rejected frame (parity, start or stop bit error).
- ovf  out  1  sticky; a make was dropped because the table was full. Cleared only by reset.

## Operation
- Receiver: 2-flop synchroniser on both lines, then a FILTER_LEN-deep level filter on the clock. Data is sampled on the filtered falling edge.
- Frame is 11 bits: start=0, 8 data LSB first, odd parity, stop=1. A valid frame produces a one-cycle byte strobe. A bad frame produces a perr pulse, no strobe, and the bit counter returns to zero.
- Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXTBRK (E0 F0), SKIP (E1 seen).
  - E0: IDLE→EXT.
  - F0: IDLE→BRK, EXT→EXTBRK.
  - Any other byte produces an event {ext, brk, code} and returns to IDLE.
  - E1 from any state: enter SKIP and discard the next 7 bytes. Pause produces no event.
  - E0 12 / E0 F0 12 (fake shifts) are discarded.
- Modifier and Fn codes update mod/Fn only, using the code set of the original keyboard block; they are never entered in the table. Shift codes are 12 and 59.
- Make of a mapped key:
  - Code already in the table (typematic repeat): no change.
  - Otherwise, map {ext, shift, code} to {valid, row, col} and store {ext, code, row, col} in a free entry; clear matrix[row][col].
  - Table full: drop the make and set ovf.
- Break: look up {ext, code}.
  - Hit: free the entry. Set matrix[row][col] to 1 only if no other valid entry holds the same position.
  - Miss: ignore.
- Unmapped codes produce no table or matrix change.

## Timing
- Reset values: matrix all ones (keyin = all ones), Fn=0, mod=0, perr=0, ovf=0, table empty, FSM IDLE, receiver bit count 0.
- Reset is asynchronous; assertion mid-frame discards the frame.
- Stop bit sampled → byte strobe on the next cycle → matrix/table/mod/Fn updated on the following cycle. Latency from stop-bit edge to updated state is 2 clk cycles.
- keyin is combinational from the matrix register and keyrow (zero latency).
- Table lookup and free-slot search are single-cycle parallel compares. The lowest-index free entry is allocated.
- The shift used for mapping is the mod[0] value before the current event.

## Configuration
- PS2_KBD_TIMEOUT_EN defined: a counter resets on every filtered clock edge. Reaching TIMEOUT_CYC with bit count ≠ 0 aborts the frame: bit count → 0, no perr, FSM state kept.
- PS2_KBD_TIMEOUT_EN undefined: no counter. A partial frame persists until 11 edges arrive.

## Structure
- Package ps2_kbd_pkg holds:
  - Prefix constants E0, E1, F0.
  - The key map entry struct {valid, row, col}.
  - The mapping function ps2_map(ext, shift, code), which carries the PET layout table.
- Sub-module ps2_rx: synchroniser, filter, frame shift register, parity/start/stop checks, timeout. Outputs byte, strobe and perr.
- The top level holds the FSM, table and matrix.

## Test plan
- Reset, then keyrow=6 → keyin=8'hFF, Fn=0, mod=0, ovf=0.
- Send 16 → keyrow 6 reads 8'hBF. Then send F0 16 → reads 8'hFF.
- Send 12, 16, F0 12, F0 16 → after the 16 make, keyrow 0 reads 8'hFE; it stays 8'hFE after shift release; 8'hFF after F0 16; row 6 never changes.
- Send 16 three times, then F0 16 once → row 6 reads 8'hFF; table empty.
- Send HOLD_DEPTH+1 distinct mapped makes → first HOLD_DEPTH positions low, last position unchanged, ovf=1.
- Send a frame with a parity error → one perr pulse, no state change. With PS2_KBD_TIMEOUT_EN defined, send 5 bits, idle TIMEOUT_CYC+10 cycles, then a full 16 frame → row 6 reads 8'hBF.
